// File: rtl/vxe_cu_exec_unit.sv
// Execution-control FSM of the VxE control unit: start/stop sequencing, NOP/SYNC dispatch halting, fault drain.
// Optional: define VXE_CU_FAULT_INTR_EN to raise o_send_intr on fault-drain completion.
module vxe_cu_exec_unit #(
  parameter int VPUS_NR = 2
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               i_start,
  output logic               o_glb_busy,
  output logic               o_halt,
  output logic               o_unhalt,
  output logic               o_stop_drain,
  output logic               o_send_intr,
  output logic               o_complete,
  input  logic               i_cmd_nop,
  input  logic               i_cmd_sync,
  input  logic               i_cmd_sync_stop,
  input  logic               i_cmd_sync_intr,
  input  logic               i_fetch_busy,
  input  logic               i_dis_pipes_active,
  input  logic               i_fwd_pipes_active,
  input  logic [VPUS_NR-1:0] i_vpus_busy,
  input  logic               i_flt_fetch,
  input  logic               i_flt_decode,
  input  logic [VPUS_NR-1:0] i_vpus_err
);

`ifdef VXE_CU_FAULT_INTR_EN
  localparam logic FAULT_INTR = 1'b1;
`else
  localparam logic FAULT_INTR = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_NOP    = 3'd2,
    S_SYNC   = 3'd3,
    S_STOP   = 3'd4,
    S_FDRAIN = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic   stop_q, stop_d;
  logic   intr_q, intr_d;

  logic   flt, synced, allidle;
  logic   busy_d, halt_d, unhalt_d, drain_d, send_intr_d, complete_d;

  assign flt     = i_flt_fetch | i_flt_decode | (|i_vpus_err);
  assign synced  = ~i_fwd_pipes_active & ~(|i_vpus_busy);
  assign allidle = synced & ~i_fetch_busy & ~i_dis_pipes_active;

  // State, latched SYNC qualifiers and all outputs are registered together
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      stop_q       <= 1'b0;
      intr_q       <= 1'b0;
      o_glb_busy   <= 1'b0;
      o_halt       <= 1'b0;
      o_unhalt     <= 1'b0;
      o_stop_drain <= 1'b0;
      o_send_intr  <= 1'b0;
      o_complete   <= 1'b0;
    end else begin
      state_q      <= state_d;
      stop_q       <= stop_d;
      intr_q       <= intr_d;
      o_glb_busy   <= busy_d;
      o_halt       <= halt_d;
      o_unhalt     <= unhalt_d;
      o_stop_drain <= drain_d;
      o_send_intr  <= send_intr_d;
      o_complete   <= complete_d;
    end
  end

  // Faults always win over commands and over the SYNC wait conditions
  always_comb begin
    state_d = state_q;
    stop_d  = stop_q;
    intr_d  = intr_q;
    case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        intr_d = 1'b0;
        if (i_start) state_d = S_RUN;
      end
      S_RUN: begin
        if (flt) begin
          state_d = S_FDRAIN;
        end else if (i_cmd_sync) begin
          state_d = S_SYNC;
          stop_d  = i_cmd_sync_stop;
          intr_d  = i_cmd_sync_intr;
        end else if (i_cmd_nop) begin
          state_d = S_NOP;
        end
      end
      S_NOP: begin
        state_d = flt ? S_FDRAIN : S_RUN;
      end
      S_SYNC: begin
        if (flt)         state_d = S_FDRAIN;
        else if (synced) state_d = stop_q ? S_STOP : S_RUN;
      end
      S_STOP: begin
        if (flt)          state_d = S_FDRAIN;
        else if (allidle) state_d = S_IDLE;
      end
      S_FDRAIN: begin
        if (allidle) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d      = (state_d != S_IDLE);
    halt_d      = (state_q == S_RUN) & ~flt & (i_cmd_sync | i_cmd_nop);
    unhalt_d    = ((state_q == S_NOP) & ~flt) |
                  ((state_q == S_SYNC) & ~flt & synced & ~stop_q);
    drain_d     = (state_d == S_FDRAIN);
    complete_d  = ((state_q == S_STOP) & ~flt & allidle) |
                  ((state_q == S_FDRAIN) & allidle);
    send_intr_d = ((state_q == S_STOP) & ~flt & allidle & intr_q) |
                  ((state_q == S_FDRAIN) & allidle & FAULT_INTR);
  end

endmodule

// File: tb/tb_vxe_cu_exec_unit.sv
// Directed testbench for vxe_cu_exec_unit: start/SYNC/NOP sequencing, fault drain and async reset.
module tb_vxe_cu_exec_unit;

`ifdef VXE_CU_FAULT_INTR_EN
  localparam logic FI = 1'b1;
`else
  localparam logic FI = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nrst;
  logic       i_start;
  logic       o_glb_busy, o_halt, o_unhalt, o_stop_drain, o_send_intr, o_complete;
  logic       i_cmd_nop, i_cmd_sync, i_cmd_sync_stop, i_cmd_sync_intr;
  logic       i_fetch_busy, i_dis_pipes_active, i_fwd_pipes_active;
  logic [1:0] i_vpus_busy;
  logic       i_flt_fetch, i_flt_decode;
  logic [1:0] i_vpus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vxe_cu_exec_unit #(.VPUS_NR(2)) dut (
    .clk                (clk),
    .nrst               (nrst),
    .i_start            (i_start),
    .o_glb_busy         (o_glb_busy),
    .o_halt             (o_halt),
    .o_unhalt           (o_unhalt),
    .o_stop_drain       (o_stop_drain),
    .o_send_intr        (o_send_intr),
    .o_complete         (o_complete),
    .i_cmd_nop          (i_cmd_nop),
    .i_cmd_sync         (i_cmd_sync),
    .i_cmd_sync_stop    (i_cmd_sync_stop),
    .i_cmd_sync_intr    (i_cmd_sync_intr),
    .i_fetch_busy       (i_fetch_busy),
    .i_dis_pipes_active (i_dis_pipes_active),
    .i_fwd_pipes_active (i_fwd_pipes_active),
    .i_vpus_busy        (i_vpus_busy),
    .i_flt_fetch        (i_flt_fetch),
    .i_flt_decode       (i_flt_decode),
    .i_vpus_err         (i_vpus_err)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected values in order: busy, halt, unhalt, stop_drain, send_intr, complete
  task automatic chk_outs(input string tag, input logic b, input logic h, input logic u,
                          input logic d, input logic i, input logic c);
    chk({tag, ".busy"},     o_glb_busy,   b);
    chk({tag, ".halt"},     o_halt,       h);
    chk({tag, ".unhalt"},   o_unhalt,     u);
    chk({tag, ".drain"},    o_stop_drain, d);
    chk({tag, ".intr"},     o_send_intr,  i);
    chk({tag, ".complete"}, o_complete,   c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_busy(input logic v);
    i_fetch_busy       = v;
    i_dis_pipes_active = v;
    i_fwd_pipes_active = v;
    i_vpus_busy        = {v, v};
  endtask

  task automatic clr_cmds();
    i_start = 0; i_cmd_nop = 0; i_cmd_sync = 0; i_cmd_sync_stop = 0; i_cmd_sync_intr = 0;
    i_flt_fetch = 0; i_flt_decode = 0; i_vpus_err = 2'b00;
  endtask

  initial begin
    nrst = 0;
    clr_cmds();
    set_busy(0);
    tick(); tick();
    chk_outs("reset", 0, 0, 0, 0, 0, 0);
    nrst = 1;
    tick();
    chk_outs("idle", 0, 0, 0, 0, 0, 0);

    // 1: SYNC+stop with everything busy, then drop busies
    set_busy(1);
    i_start = 1; tick(); clr_cmds();
    chk_outs("t1.start", 1, 0, 0, 0, 0, 0);
    i_cmd_sync = 1; i_cmd_sync_stop = 1; tick(); clr_cmds();
    chk_outs("t1.halt", 1, 1, 0, 0, 0, 0);
    tick();
    chk_outs("t1.wait", 1, 0, 0, 0, 0, 0);
    set_busy(0); tick();
    chk_outs("t1.stop", 1, 0, 0, 0, 0, 0);
    tick();
    chk_outs("t1.complete", 0, 0, 0, 0, 0, 1);
    tick();
    chk_outs("t1.after", 0, 0, 0, 0, 0, 0);

    // 2: plain SYNC then unhalt; SYNC+stop+intr already synced
    i_fetch_busy = 1; i_dis_pipes_active = 1; i_fwd_pipes_active = 1; i_vpus_busy = 2'b01;
    i_start = 1; tick(); clr_cmds();
    chk_outs("t2.start", 1, 0, 0, 0, 0, 0);
    i_cmd_sync = 1; tick(); clr_cmds();
    chk_outs("t2.halt", 1, 1, 0, 0, 0, 0);
    tick();
    chk_outs("t2.wait", 1, 0, 0, 0, 0, 0);
    i_fwd_pipes_active = 0; i_vpus_busy = 2'b00; tick();
    chk_outs("t2.unhalt", 1, 0, 1, 0, 0, 0);
    i_cmd_sync = 1; i_cmd_sync_stop = 1; i_cmd_sync_intr = 1; tick(); clr_cmds();
    chk_outs("t2.halt2", 1, 1, 0, 0, 0, 0);
    tick();
    chk_outs("t2.stop", 1, 0, 0, 0, 0, 0);
    tick();
    chk_outs("t2.stopwait", 1, 0, 0, 0, 0, 0);
    i_fetch_busy = 0; i_dis_pipes_active = 0; tick();
    chk_outs("t2.complete", 0, 0, 0, 0, 1, 1);

    // 3: all fault sources at once, drain held until idle
    set_busy(1);
    i_start = 1; tick(); clr_cmds();
    i_flt_fetch = 1; i_flt_decode = 1; i_vpus_err = 2'b11; tick(); clr_cmds();
    chk_outs("t3.drain", 1, 0, 0, 1, 0, 0);
    tick(); tick();
    chk_outs("t3.hold", 1, 0, 0, 1, 0, 0);
    set_busy(0); tick();
    chk_outs("t3.complete", 0, 0, 0, 0, FI, 1);
    tick();
    chk_outs("t3.after", 0, 0, 0, 0, 0, 0);

    // 4: fault coincident with SYNC+stop+intr is a fault only
    set_busy(1);
    i_start = 1; tick(); clr_cmds();
    i_cmd_sync = 1; i_cmd_sync_stop = 1; i_cmd_sync_intr = 1; i_flt_fetch = 1; i_flt_decode = 1;
    tick(); clr_cmds();
    chk_outs("t4.drain", 1, 0, 0, 1, 0, 0);
    set_busy(0); tick();
    chk_outs("t4.complete", 0, 0, 0, 0, FI, 1);
    tick();
    chk_outs("t4.once", 0, 0, 0, 0, 0, 0);

    // 5: NOP halt/unhalt on consecutive cycles, then SYNC stop+intr
    i_start = 1; tick(); clr_cmds();
    i_cmd_nop = 1; tick(); clr_cmds();
    chk_outs("t5.halt", 1, 1, 0, 0, 0, 0);
    tick();
    chk_outs("t5.unhalt", 1, 0, 1, 0, 0, 0);
    tick();
    chk_outs("t5.run", 1, 0, 0, 0, 0, 0);
    i_cmd_sync = 1; i_cmd_sync_stop = 1; i_cmd_sync_intr = 1; tick(); clr_cmds();
    chk_outs("t5.halt2", 1, 1, 0, 0, 0, 0);
    tick();
    chk_outs("t5.stop", 1, 0, 0, 0, 0, 0);
    tick();
    chk_outs("t5.complete", 0, 0, 0, 0, 1, 1);

    // 6: start while busy is ignored; async reset mid-drain
    set_busy(1);
    i_start = 1; tick();
    chk_outs("t6.start", 1, 0, 0, 0, 0, 0);
    tick(); clr_cmds();
    chk_outs("t6.restart", 1, 0, 0, 0, 0, 0);
    i_flt_decode = 1; tick(); clr_cmds();
    chk_outs("t6.drain", 1, 0, 0, 1, 0, 0);
    #2 nrst = 0;
    #1;
    chk_outs("t6.reset", 0, 0, 0, 0, 0, 0);
    tick();
    nrst = 1;
    tick();
    chk_outs("t6.idle", 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vxe_cu_exec_unit.md
Name: vxe_cu_exec_unit

Overview:
Execution-control FSM inside the VxE control unit (CU). It starts execution on an external start pulse and reports global busy. It sequences NOP and SYNC commands from decode by halting and unhalting instruction dispatch. On faults or SYNC-with-stop it drains all pipes, then signals completion and optionally an interrupt.

Parameters:
VPUS_NR, 2, number of vector processing units; sets the width of i_vpus_busy and i_vpus_err.

Ports:
clk  in  1  clock; single clock domain, everything on rising edge
nrst  in  1  reset, asynchronous assert, active-low (clock clk, reset nrst, as named in the codebase)
i_start  in  1  start-execution pulse
o_glb_busy  out  1  unit active (any state except IDLE)
o_halt  out  1  1-cycle pulse: halt instruction dispatch
o_unhalt  out  1  1-cycle pulse: resume instruction dispatch
o_stop_drain  out  1  level: discard remaining work and drain (fault handling)
o_send_intr  out  1  1-cycle pulse: raise interrupt
o_complete  out  1  1-cycle pulse: execution finished
i_cmd_nop  in  1  NOP command decoded (pulse)
i_cmd_sync  in  1  SYNC command decoded (pulse)
i_cmd_sync_stop  in  1  SYNC qualifier: stop after sync; valid with i_cmd_sync
i_cmd_sync_intr  in  1  SYNC qualifier: interrupt on stop; valid with i_cmd_sync
i_fetch_busy  in  1  fetch unit busy
i_dis_pipes_active  in  1  dispatch pipes active
i_fwd_pipes_active  in  1  forwarding pipes active
i_vpus_busy  in  VPUS_NR  per-VPU busy
i_flt_fetch  in  1  fetch fault (pulse)
i_flt_decode  in  1  decode fault (pulse)
i_vpus_err  in  VPUS_NR  per-VPU error (pulse)

Behaviour:
- All outputs registered; reset value 0. State resets to IDLE; latched flags clear.
- Definitions:
  - FLT = i_flt_fetch | i_flt_decode | (|i_vpus_err).
  - SYNCED = !i_fwd_pipes_active & !(|i_vpus_busy).
  - ALLIDLE = SYNCED & !i_fetch_busy & !i_dis_pipes_active.
- IDLE: o_glb_busy=0. If i_start is sampled at edge N, go to RUN and set o_glb_busy=1 after edge N. Cmd and fault inputs are ignored in IDLE.
- RUN: priority is FLT > i_cmd_sync > i_cmd_nop.
  - FLT: go to FDRAIN and set o_stop_drain=1.
  - i_cmd_sync: pulse o_halt, latch stop_f=i_cmd_sync_stop and intr_f=i_cmd_sync_intr, go to SYNC.
  - i_cmd_nop: pulse o_halt, go to NOP.
- NOP: one cycle; pulse o_unhalt, go back to RUN. FLT here takes priority and goes to FDRAIN with no unhalt.
- SYNC: wait for SYNCED.
  - If stop_f=0: pulse o_unhalt, go to RUN.
  - If stop_f=1: go to STOP.
  - If SYNCED holds on the first SYNC cycle, exit on that cycle.
- STOP: wait for ALLIDLE, then pulse o_complete, pulse o_send_intr if intr_f, and go to IDLE (o_glb_busy=0 on the same edge).
- FDRAIN: hold o_stop_drain=1 until ALLIDLE. Then clear o_stop_drain, pulse o_complete and o_send_intr (see Optional Feature), and go to IDLE.
- FLT seen in SYNC or STOP also goes to FDRAIN; the fault overrides the SYNC flags.
- FLT asserted on the same cycle as i_cmd_sync (with stop/intr) is handled as a fault only.
- i_start is ignored outside IDLE. A new start is accepted the cycle after o_complete.
- Completion pulses occur exactly once per run. o_halt and o_unhalt are never asserted in the same cycle.
- Reset mid-operation: immediately return to IDLE with all outputs 0.

Optional Feature:
VXE_CU_FAULT_INTR_EN: when defined, fault-drain completion asserts o_send_intr together with o_complete. When undefined, fault-drain completion asserts only o_complete; o_send_intr then comes only from SYNC-stop with intr_f=1. The test plan below assumes the macro is defined.

Test Plan:
- Reset, then i_start pulse with all busies=1 -> o_glb_busy=1 next cycle, all other outputs 0. SYNC+stop pulse -> o_halt pulse. Later drop all busies to 0 -> o_complete pulse, o_send_intr=0, o_glb_busy=0.
- Start; plain SYNC with fwd/vpus busy -> o_halt, no unhalt. Clear fwd and vpus_busy=2'b00 -> o_unhalt pulse. SYNC+stop+intr (already synced) -> o_halt. Clear fetch/dis -> o_complete and o_send_intr pulse together.
- Start; one-cycle pulse of flt_fetch, flt_decode and vpus_err=2'b11 -> o_stop_drain=1, held until all busies=0. Then o_stop_drain=0 with o_complete and o_send_intr pulses.
- Start; SYNC+stop+intr in the same cycle as flt_fetch/flt_decode -> fault path: o_stop_drain=1, no o_halt. All idle -> one o_complete and one o_send_intr.
- Start; i_cmd_nop pulse -> o_halt then o_unhalt on consecutive cycles, o_glb_busy stays 1. Then SYNC+stop+intr and idle -> complete plus interrupt.
- i_start pulsed while busy -> ignored. nrst asserted mid-drain -> all outputs 0 immediately.
